// File: rtl/fp_cmp_wb.sv
// fp_cmp_wb: FP compare writeback buffer (2-entry) with sticky fflags; FP_CMP_WB_CNT_EN adds a retire counter
module fp_cmp_wb #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_valid,
  output logic                      out_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_flag_NV,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic                      out_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] out_wr_addr,
  output logic [DATA_WIDTH-1:0]     out_wr_data,
  input  logic                      in_wr_ack,
  input  logic                      in_fflags_clr,
`ifdef FP_CMP_WB_CNT_EN
  output logic [15:0]               out_cmp_count,
`endif
  output logic [4:0]                out_fflags
);
  localparam int EW = REG_ADDR_WIDTH + 2;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] e0_q, e0_d, e1_q, e1_d, in_e;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic nv_q, nv_d, push, pop, busy, unused_data;
  assign unused_data = ^in_data[DATA_WIDTH-1:1];
  assign in_e = {in_rd, in_data[0], in_flag_NV};
  assign head_rd = e0_q[EW-1:2];
  assign busy = state_q != EMPTY;
  assign out_ready = state_q != FULL;
  assign out_wr_en = busy && head_rd != '0;
  assign out_wr_addr = busy ? head_rd : '0;
  assign out_wr_data = {{(DATA_WIDTH-1){1'b0}}, busy & e0_q[1]};
  assign out_fflags = {nv_q, 4'b0};
  // handshake decode, next state, shift-FIFO contents and sticky NV
  always_comb begin
    push = in_valid && out_ready;
    pop = busy && (head_rd == '0 || in_wr_ack);
    state_d = state_q == EMPTY ? (push ? ONE : EMPTY)
            : state_q == ONE   ? (push && !pop ? FULL : !push && pop ? EMPTY : ONE)
            :                    (pop ? ONE : FULL);
    e0_d = pop ? (state_q == FULL ? e1_q : in_e) : (busy ? e0_q : in_e);
    e1_d = (state_q == ONE && push && !pop) ? in_e : e1_q;
    nv_d = (in_fflags_clr ? 1'b0 : nv_q) | (pop & e0_q[0]);
  end
  // state and buffer registers
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= EMPTY;
      e0_q <= '0;
      e1_q <= '0;
      nv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      nv_q <= nv_d;
    end
  end
`ifdef FP_CMP_WB_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 16'(pop);
  assign out_cmp_count = cnt_q;
  // retired-entry counter, wraps naturally at 16 bits
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_fp_cmp_wb.sv
// tb_fp_cmp_wb: scoreboard bench for fp_cmp_wb with queue-based reference model
module tb_fp_cmp_wb;
  localparam int DW = 64, AW = 5;
  logic clk = 0, rst = 1, valid = 0, nv = 0, ack = 0, clr = 0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] rd = '0;
  logic out_ready, out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;
  logic [4:0] out_fflags;
`ifdef FP_CMP_WB_CNT_EN
  logic [15:0] cmp_count;
`endif
  typedef struct packed {logic [AW-1:0] rd; logic b; logic nv;} ent_t;
  ent_t q[$];
  ent_t h;
  int tests = 0, fails = 0;
  logic exp_nv = 0, ret, nv_ret;
  logic [15:0] exp_cnt = 0;

  fp_cmp_wb #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .in_clk(clk), .in_rst(rst), .in_valid(valid), .out_ready(out_ready),
    .in_data(data), .in_flag_NV(nv), .in_rd(rd), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .in_wr_ack(ack),
    .in_fflags_clr(clr),
`ifdef FP_CMP_WB_CNT_EN
    .out_cmp_count(cmp_count),
`endif
    .out_fflags(out_fflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: compare DUT head against model queue, then retire per model rules
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_nv = 0;
      exp_cnt = 0;
    end else begin
      ret = 0;
      nv_ret = 0;
      chk("ready", out_ready, q.size() < 2);
      chk("fflags", out_fflags, {exp_nv, 4'b0});
`ifdef FP_CMP_WB_CNT_EN
      chk("count", cmp_count, exp_cnt);
`endif
      if (q.size() == 0) chk("idle_wr_en", out_wr_en, 0);
      else begin
        h = q[0];
        if (h.rd == 0) begin
          chk("x0_wr_en", out_wr_en, 0);
          ret = 1;
        end else begin
          chk("wr_en", out_wr_en, 1);
          chk("wr_addr", out_wr_addr, h.rd);
          chk("wr_data", out_wr_data, {63'b0, h.b});
          ret = ack;
        end
        nv_ret = ret & h.nv;
      end
      exp_nv = clr ? nv_ret : (exp_nv | nv_ret);
      if (ret) begin
        void'(q.pop_front());
        exp_cnt++;
      end
    end
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic n, input logic [AW-1:0] r,
                     input logic a, input logic c, output logic acc);
    valid = v; data = d; nv = n; rd = r; ack = a; clr = c;
    @(negedge clk);
    acc = v && out_ready;
    @(posedge clk);
    if (acc) q.push_back(ent_t'{r, d[0], n});
    #1;
  endtask

  task automatic idle(input logic a, input logic c);
    logic acc;
    cyc(0, '0, 0, '0, a, c, acc);
  endtask

  task automatic send(input logic [63:0] d, input logic n, input logic [AW-1:0] r, input logic a);
    logic acc = 0;
    for (int k = 0; k < 20 && !acc; k++) cyc(1, d, n, r, a, 0, acc);
    chk("send_accept", acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [AW-1:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", out_ready, 1);
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_addr", out_wr_addr, 0);
    chk("rst_data", out_wr_data, 0);
    chk("rst_fflags", out_fflags, 0);
    rst = 0;
    send(64'h1, 0, 5, 0);
    idle(1, 0);
    idle(0, 0);
    cyc(1, 64'h1, 0, 7, 0, 0, acc);
    cyc(1, 64'h0, 1, 8, 0, 0, acc);
    cyc(1, 64'h1, 0, 9, 0, 0, acc);
    chk("bp_third_held", acc, 0);
    chk("bp_ready", out_ready, 0);
    send(64'h1, 0, 9, 1);
    repeat (3) idle(1, 0);
    send(64'h1, 1, 0, 0);
    repeat (2) idle(0, 0);
    chk("x0_fflags", out_fflags, 5'b10000);
    send(64'h1, 1, 0, 0);
    idle(0, 1);
    chk("clr_vs_set", out_fflags, 5'b10000);
    idle(0, 1);
    chk("clr_alone", out_fflags, 5'b00000);
    send(64'hFFFF_FFFF_FFFF_FFFE, 0, 3, 0);
    repeat (2) idle(1, 0);
    repeat (400) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), r,
          $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, acc);
    end
    repeat (4) idle(1, 0);
    send(64'h1, 1, 4, 0);
    send(64'h1, 1, 6, 0);
    chk("full_ready", out_ready, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_wr_en", out_wr_en, 0);
    chk("mid_rst_ready", out_ready, 1);
    chk("mid_rst_fflags", out_fflags, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) idle(1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_cmp_wb.md
# fp_cmp_wb

Writeback stage directly downstream of the FP compare unit. Captures each compare result (the 0/1 data word and NV flag) with its destination integer register index into a 2-entry buffer. Drains entries to the integer register-file write port under a valid/ack handshake. Accumulates a sticky FP exception-flag register (fflags) as entries retire.

## Interface

Parameters:
- DATA_WIDTH, 64, width of compare result and register write data
- REG_ADDR_WIDTH, 5, width of destination register index

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are in_clk and in_rst.
- in_clk  input  1  clock; all state updates on rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream compare result valid this cycle
- out_ready  output  1  stage can accept an entry this cycle
- in_data  input  DATA_WIDTH  compare result word; only bit 0 is meaningful
- in_flag_NV  input  1  invalid-operation flag from comparator
- in_rd  input  REG_ADDR_WIDTH  destination integer register
- out_wr_en  output  1  register-file write request
- out_wr_addr  output  REG_ADDR_WIDTH  write address (head entry rd)
- out_wr_data  output  DATA_WIDTH  write data, {zeros, head result bit}
- in_wr_ack  input  1  register file accepted the write this cycle
- in_fflags_clr  input  1  synchronous clear of sticky flags
- out_fflags  output  5  sticky flags {NV,DZ,OF,UF,NX}; only NV (bit 4) is ever set here

## Operation

- Buffer is a 2-entry FIFO, state EMPTY / ONE / FULL. Each entry is {rd, result bit, NV}.
- Push: in_valid & out_ready. Entry is written at the tail; in_data[DATA_WIDTH-1:1] is discarded.
- out_ready = (state != FULL). It is a registered-state decode, with no combinational path from in_wr_ack.
- Head presentation, state != EMPTY:
  - rd != 0: out_wr_en=1, out_wr_addr=head rd, out_wr_data={(DATA_WIDTH-1)'b0, head bit}.
  - rd == 0: out_wr_en=0. The entry retires unconditionally that cycle (x0 write suppressed).
- Pop (retire):
  - rd != 0 & in_wr_ack: retire.
  - rd == 0: retire automatically.
  - in_wr_ack while out_wr_en=0 is ignored.
- Transitions:
  - EMPTY → ONE on push.
  - ONE → FULL on push without pop.
  - ONE → EMPTY on pop without push.
  - ONE stays ONE on simultaneous push+pop.
  - FULL → ONE on pop. No push is possible while FULL.
- Flags:
  - On retire, out_fflags[4] |= head NV.
  - in_fflags_clr clears all 5 bits.
  - Clear and a retiring NV=1 in the same cycle: result is NV=1 (set wins).
  - Bits [3:0] stay 0.
- Retire order equals accept order.
- Entry data is held stable while out_wr_en=1 and not acked.

## Timing

- Latency: entry accepted at edge N is presented on out_wr_* after edge N (visible in cycle N+1). Minimum one cycle accept-to-write.
- Throughput: one entry per cycle when in_wr_ack is held high.
- Flag update is visible the cycle after the retiring edge.
- Reset values:
  - state EMPTY, out_ready=1
  - out_wr_en=0, out_wr_addr=0, out_wr_data=0
  - out_fflags=0, counter=0
- Reset asserted mid-operation: buffered entries are discarded with no write issued, and flags are cleared. out_ready=1 in the first cycle after deassertion.
- Outputs are glitch-free registered or state-decoded. No combinational in_valid→out_wr_en path.

## Configuration

- FP_CMP_WB_CNT_EN defined:
  - Adds output out_cmp_count [15:0]: number of retired entries, including rd==0 entries.
  - Wraps 16'hFFFF→0.
  - Reset to 0.
  - Not cleared by in_fflags_clr.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan

- Single entry: push rd=5, data=64'h1, NV=0; ack next cycle → out_wr_en=1, addr=5, data=64'h1 one cycle after accept; state EMPTY after ack; out_fflags=0.
- Backpressure: push 3 back-to-back with in_wr_ack=0 → first two accepted, out_ready=0 in the third cycle, third held upstream; release ack → writes in order rd A,B, then C accepted.
- x0 suppression: push rd=0, NV=1, data=64'h1 → out_wr_en never asserted, entry retires in one cycle, out_fflags=5'b10000.
- Clear vs set collision: fflags NV=1; assert in_fflags_clr while an NV=1 entry retires → out_fflags=5'b10000. Clear alone next cycle → 5'b00000.
- Data sanitising: push data=64'hFFFF_FFFF_FFFF_FFFE, rd=3 → out_wr_data=64'h0.
- Reset mid-flight: FULL with ack=0, pulse in_rst → out_wr_en=0, out_ready=1, out_fflags=0, no write of flushed entries after release.
- With FP_CMP_WB_CNT_EN: preload via 65537 retires → out_cmp_count=1.
